// File: rtl/score_pkg.sv
// score_pkg
//   Shared types and default parameters for the score tracker slice.
//   - score_state_t : two-state scoring FSM (RUN counts, SAT parks at MAX)
//   - DEFAULT_*     : parameter defaults used by score_tracker
package score_pkg;

  typedef enum logic {
    RUN = 1'b0,
    SAT = 1'b1
  } score_state_t;

  localparam int unsigned DEFAULT_WIDTH    = 10;
  localparam int unsigned DEFAULT_STEP     = 1;
  localparam bit          DEFAULT_SATURATE = 1'b1;

endpackage

// File: rtl/score_tracker_edge_pulse.sv
// edge_pulse
//   Rising-edge detector for a raw level input. The previous level is
//   registered every cycle regardless of what the consumer does with the
//   pulse. As a result, an edge that the consumer ignores is consumed and
//   is not presented again later.
//   Ports:
//     clk_i  : system clock
//     rst_ni : asynchronous active-low reset (previous level forced to 0)
//     in_i   : raw level
//     out_o  : combinational pulse, high when in_i=1 and the registered level is 0
module edge_pulse (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic out_o
);

  logic level_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= 1'b0;
    end else begin
      level_q <= in_i;
    end
  end

  // Because level_q resets to 0, a level that is already high when reset
  // is released produces exactly one pulse.
  assign out_o = in_i & ~level_q;

endmodule

// File: rtl/score_tracker.sv
// score_tracker
//   Counts rising edges of a "point scored" level. Each counted edge adds
//   STEP to the score. On overflow, the score either saturates at MAX or
//   wraps modulo 2^WIDTH. The tracker also keeps a high score that lasts
//   until reset. All outputs are registered.
//   Parameters:
//     WIDTH    : score width, MAX = 2^WIDTH-1
//     STEP     : increment per counted edge (1..MAX)
//     SATURATE : 1 = clamp at MAX, 0 = wrap
//   Ports:
//     clk_i        : system clock
//     rst_ni       : asynchronous active-low reset
//     on_i         : raw scoring level, only 0->1 transitions count
//     screen_i     : title/game-over screen, clears the score (not the high score)
//     pause_i      : while high, scoring edges are dropped
//     score_o      : current score
//     high_score_o : best score since reset
//     new_high_o   : sticky flag, set when this game beats the high score
//     at_max_o     : score parked at MAX (saturating build only)
//     wrapped_o    : one-cycle pulse when the score wraps (wrapping build only)
module score_tracker
  import score_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned STEP     = DEFAULT_STEP,
  parameter bit          SATURATE = DEFAULT_SATURATE
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             on_i,
  input  logic             screen_i,
  input  logic             pause_i,
  output logic [WIDTH-1:0] score_o,
  output logic [WIDTH-1:0] high_score_o,
  output logic             new_high_o,
  output logic             at_max_o,
  output logic             wrapped_o
);

  localparam logic [WIDTH-1:0] MAX      = '1;
  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);

  score_state_t     state_q, state_d;
  logic [WIDTH-1:0] score_q, score_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             new_high_q, new_high_d;
  logic             at_max_q, at_max_d;
  logic             wrapped_q, wrapped_d;

  logic             hit;
  logic             accept;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic [WIDTH-1:0] next_val;

  edge_pulse u_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .in_i   (on_i),
    .out_o  (hit)
  );

  // The sum is one bit wider than the score. Its top bit is therefore
  // exactly the condition sum > MAX.
  assign sum   = {1'b0, score_q} + STEP_EXT;
  assign carry = sum[WIDTH];

  always_comb begin
    next_val = sum[WIDTH-1:0];
    if (SATURATE && carry) begin
      next_val = MAX;
    end
  end

  assign accept = hit & ~pause_i & ~screen_i & (state_q == RUN);

  // Priority order: screen clear, then pause (folded into accept), then scoring.
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    new_high_d = new_high_q;
    wrapped_d  = 1'b0;

    if (screen_i) begin
      score_d    = '0;
      new_high_d = 1'b0;
      state_d    = RUN;
    end else if (accept) begin
      score_d = next_val;
      if (!SATURATE && carry) begin
        wrapped_d = 1'b1;
      end
      if (SATURATE && (next_val == MAX)) begin
        state_d = SAT;
      end
      // Only a strictly higher score counts as a new high. In wrap mode,
      // the wrapped value is small, so the pre-wrap peak is kept.
      if (next_val > high_q) begin
        high_d     = next_val;
        new_high_d = 1'b1;
      end
    end

    at_max_d = SATURATE && (score_d == MAX);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      score_q    <= '0;
      high_q     <= '0;
      new_high_q <= 1'b0;
      at_max_q   <= 1'b0;
      wrapped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
      at_max_q   <= at_max_d;
      wrapped_q  <= wrapped_d;
    end
  end

  assign score_o      = score_q;
  assign high_score_o = high_q;
  assign new_high_o   = new_high_q;
  assign at_max_o     = at_max_q;
  assign wrapped_o    = wrapped_q;

endmodule

// File: tb/tb_score_tracker.sv
// tb_score_tracker
//   Drives three builds of score_tracker from one shared stimulus stream:
//     inst 0 : WIDTH=10 STEP=1 SATURATE=1 (defaults)
//     inst 1 : WIDTH=4  STEP=3 SATURATE=1
//     inst 2 : WIDTH=4  STEP=3 SATURATE=0
//   An integer game model predicts every output each cycle. Literal
//   expectations at key points pin down the model's behaviour.
module tb_score_tracker;

  localparam int PW   [0:2] = '{10, 4, 4};
  localparam int PS   [0:2] = '{1, 3, 3};
  localparam int PSAT [0:2] = '{1, 1, 0};

  logic clk = 1'b0;
  logic rst_n;
  logic on;
  logic screen;
  logic pause;

  logic [9:0] score0, high0;
  logic [3:0] score1, high1, score2, high2;
  logic       newh0, newh1, newh2;
  logic       atmax0, atmax1, atmax2;
  logic       wrap0, wrap1, wrap2;

  int compared   = 0;
  int mismatched = 0;
  bit checkEnable = 1'b0;

  int mScore [0:2] = '{0, 0, 0};
  int mHigh  [0:2] = '{0, 0, 0};
  bit mNew   [0:2] = '{0, 0, 0};
  bit mAtMax [0:2] = '{0, 0, 0};
  bit mWrap  [0:2] = '{0, 0, 0};
  bit mPrevOn = 1'b0;

  always #5 clk = ~clk;

  score_tracker u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .on_i(on), .screen_i(screen), .pause_i(pause),
    .score_o(score0), .high_score_o(high0), .new_high_o(newh0),
    .at_max_o(atmax0), .wrapped_o(wrap0)
  );

  score_tracker #(.WIDTH(4), .STEP(3), .SATURATE(1'b1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .on_i(on), .screen_i(screen), .pause_i(pause),
    .score_o(score1), .high_score_o(high1), .new_high_o(newh1),
    .at_max_o(atmax1), .wrapped_o(wrap1)
  );

  score_tracker #(.WIDTH(4), .STEP(3), .SATURATE(1'b0)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .on_i(on), .screen_i(screen), .pause_i(pause),
    .score_o(score2), .high_score_o(high2), .new_high_o(newh2),
    .at_max_o(atmax2), .wrapped_o(wrap2)
  );

  function automatic logic [31:0] dutScore(input int i);
    case (i)
      0:       return 32'(score0);
      1:       return 32'(score1);
      default: return 32'(score2);
    endcase
  endfunction

  function automatic logic [31:0] dutHigh(input int i);
    case (i)
      0:       return 32'(high0);
      1:       return 32'(high1);
      default: return 32'(high2);
    endcase
  endfunction

  function automatic logic [31:0] dutNew(input int i);
    case (i)
      0:       return 32'(newh0);
      1:       return 32'(newh1);
      default: return 32'(newh2);
    endcase
  endfunction

  function automatic logic [31:0] dutAtMax(input int i);
    case (i)
      0:       return 32'(atmax0);
      1:       return 32'(atmax1);
      default: return 32'(atmax2);
    endcase
  endfunction

  function automatic logic [31:0] dutWrap(input int i);
    case (i)
      0:       return 32'(wrap0);
      1:       return 32'(wrap1);
      default: return 32'(wrap2);
    endcase
  endfunction

  // Game rules in plain integers: add STEP, then clamp or take the
  // remainder. The high score only moves upward.
  function automatic int maxOf(input int i);
    return (1 << PW[i]) - 1;
  endfunction

  function automatic int nextScore(input int i, input int cur);
    int total;
    total = cur + PS[i];
    if (PSAT[i] != 0) return (total > maxOf(i)) ? maxOf(i) : total;
    return total % (maxOf(i) + 1);
  endfunction

  function automatic bit wrapsAt(input int i, input int cur);
    return (PSAT[i] == 0) && (cur + PS[i] > maxOf(i));
  endfunction

  wire modelHit = on & ~mPrevOn & ~pause & ~screen;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mScore[i] <= 0;
        mHigh[i]  <= 0;
        mNew[i]   <= 1'b0;
        mAtMax[i] <= 1'b0;
        mWrap[i]  <= 1'b0;
      end
      mPrevOn <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (screen) begin
          mScore[i] <= 0;
          mNew[i]   <= 1'b0;
          mAtMax[i] <= 1'b0;
          mWrap[i]  <= 1'b0;
        end else if (modelHit) begin
          mScore[i] <= nextScore(i, mScore[i]);
          mWrap[i]  <= wrapsAt(i, mScore[i]);
          mAtMax[i] <= (PSAT[i] != 0) && (nextScore(i, mScore[i]) == maxOf(i));
          if (nextScore(i, mScore[i]) > mHigh[i]) begin
            mHigh[i] <= nextScore(i, mScore[i]);
            mNew[i]  <= 1'b1;
          end
        end else begin
          mWrap[i]  <= 1'b0;
          mAtMax[i] <= (PSAT[i] != 0) && (mScore[i] == maxOf(i));
        end
      end
      mPrevOn <= on;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Every falling edge: all outputs of all three builds against the model.
  always @(negedge clk) begin
    if (checkEnable) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("model score[%0d]", i), dutScore(i), 32'(mScore[i]));
        checkOutput($sformatf("model high[%0d]", i), dutHigh(i), 32'(mHigh[i]));
        checkOutput($sformatf("model new_high[%0d]", i), dutNew(i), 32'(mNew[i]));
        checkOutput($sformatf("model at_max[%0d]", i), dutAtMax(i), 32'(mAtMax[i]));
        checkOutput($sformatf("model wrapped[%0d]", i), dutWrap(i), 32'(mWrap[i]));
      end
    end
  end

  // Sets the inputs and lets exactly one rising edge sample them. Returns 1
  // time unit after that edge.
  task automatic applyStimulus(input logic o, input logic s, input logic p);
    on     = o;
    screen = s;
    pause  = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic p);
    repeat (n) applyStimulus(1'b0, 1'b0, p);
  endtask

  int satTable [0:4] = '{3, 6, 9, 12, 15};

  initial begin
    rst_n  = 1'b0;
    on     = 1'b0;
    screen = 1'b0;
    pause  = 1'b0;
    #12;
    for (int i = 0; i < 3; i++) begin
      checkOutput("reset score", dutScore(i), 32'd0);
      checkOutput("reset high", dutHigh(i), 32'd0);
      checkOutput("reset new_high", dutNew(i), 32'd0);
      checkOutput("reset at_max", dutAtMax(i), 32'd0);
      checkOutput("reset wrapped", dutWrap(i), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkEnable = 1'b1;

    // Five isolated one-cycle pulses.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("pulse score0", dutScore(0), 32'(k + 1));
      checkOutput("pulse score1 sat", dutScore(1), 32'(satTable[k]));
      checkOutput("pulse score2 wrap", dutScore(2), 32'(satTable[k]));
      checkOutput("pulse at_max1", dutAtMax(1), (k == 4) ? 32'd1 : 32'd0);
      idle(5, 1'b0);
    end
    checkOutput("five high0", dutHigh(0), 32'd5);
    checkOutput("five new_high0", dutNew(0), 32'd1);
    checkOutput("five at_max2", dutAtMax(2), 32'd0);

    // Level held high for 20 cycles counts once.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("held score0", dutScore(0), 32'd6);
    checkOutput("sat 6th ignored", dutScore(1), 32'd15);
    checkOutput("sat at_max held", dutAtMax(1), 32'd1);
    checkOutput("wrap score2", dutScore(2), 32'd2);
    checkOutput("wrap pulse", dutWrap(2), 32'd1);
    checkOutput("wrap high2", dutHigh(2), 32'd15);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("wrap pulse ends", dutWrap(2), 32'd0);
    repeat (18) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("held 20 score0", dutScore(0), 32'd6);
    idle(3, 1'b0);

    // Reach 7, then screen coincident with an edge.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("score0 at 7", dutScore(0), 32'd7);
    idle(5, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("screen score0", dutScore(0), 32'd0);
    checkOutput("screen high0", dutHigh(0), 32'd7);
    checkOutput("screen new_high0", dutNew(0), 32'd0);
    checkOutput("screen high2", dutHigh(2), 32'd15);
    idle(5, 1'b0);

    // A second game ties the high score at 7, then beats it at 8.
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      idle(2, 1'b0);
    end
    checkOutput("tie score0", dutScore(0), 32'd7);
    checkOutput("tie new_high0", dutNew(0), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("beat high0", dutHigh(0), 32'd8);
    checkOutput("beat new_high0", dutNew(0), 32'd1);
    idle(3, 1'b0);

    // Paused edges are lost. Releasing pause while on is high does not count.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      idle(2, 1'b1);
    end
    checkOutput("pause score0", dutScore(0), 32'd8);
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("unpause high level", dutScore(0), 32'd8);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("unpause fresh edge", dutScore(0), 32'd9);
    idle(3, 1'b0);

    // Asynchronous reset mid-cycle at score 9, then release with on high.
    checkOutput("pre-reset score0", dutScore(0), 32'd9);
    #2;
    rst_n = 1'b0;
    on    = 1'b1;
    #1;
    checkOutput("async score0", dutScore(0), 32'd0);
    checkOutput("async high0", dutHigh(0), 32'd0);
    checkOutput("async new_high0", dutNew(0), 32'd0);
    checkOutput("async at_max1", dutAtMax(1), 32'd0);
    checkOutput("async high2", dutHigh(2), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("release count", dutScore(0), 32'd1);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("release once", dutScore(0), 32'd1);
    checkOutput("release new_high0", dutNew(0), 32'd1);
    checkOutput("release score1", dutScore(1), 32'd3);
    idle(2, 1'b0);

    checkEnable = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
